// File: rtl/fetch_queue.sv
// fetch_queue: PC generator, MEM_LAT-stage imem request tracker and DEPTH-entry
// instruction queue feeding decode. Define FETCH_QUEUE_PERF_EN for perf counters.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       global_en,
  output logic                       imem_req,
  output logic [31:0]                imem_raddr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pcadd4,
  output logic [31:0]                out_inst,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_redirect_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int          PTR_W = $clog2(DEPTH);
  localparam int          CNT_W = $clog2(DEPTH+1);
  localparam int          OCC_W = CNT_W + 3;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic [31:0]        fetch_pc;
  logic [MEM_LAT-1:0] vld_p;
  logic [31:0]        pc_p [MEM_LAT];
  logic [31:0]        q_pc     [DEPTH];
  logic [31:0]        q_pcadd4 [DEPTH];
  logic [31:0]        q_inst   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [OCC_W-1:0]   occ;
  logic               issue;
  logic               push;
  logic               pop;

  // Credit = queued entries plus requests still travelling through memory.
  always_comb begin
    occ = OCC_W'(count);
    for (int i = 0; i < MEM_LAT; i++) begin
      occ = occ + OCC_W'(vld_p[i]);
    end
  end

  assign issue      = rst_n && global_en && !redirect && (occ < OCC_W'(DEPTH));
  assign push       = global_en && !redirect && vld_p[MEM_LAT-1];
  assign pop        = global_en && !redirect && out_valid && out_ready;
  assign imem_req   = issue;
  assign imem_raddr = fetch_pc;

  // Stage p0..p(MEM_LAT-1): request tracking alongside the imem pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      vld_p    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (global_en) begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
        vld_p    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        vld_p[0] <= issue;
        for (int i = 1; i < MEM_LAT; i++) begin
          vld_p[i] <= vld_p[i-1];
        end
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (global_en) begin
      pc_p[0] <= fetch_pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        pc_p[i] <= pc_p[i-1];
      end
      if (push) begin
        q_pc[wr_ptr]     <= pc_p[MEM_LAT-1];
        q_pcadd4[wr_ptr] <= pc_p[MEM_LAT-1] + 32'd4;
        q_inst[wr_ptr]   <= imem_rdata;
      end
    end
  end

  // Queue head: registered storage, masked to reset values when empty.
  assign out_valid  = (count != CNT_W'(0));
  assign out_pc     = out_valid ? q_pc[rd_ptr]     : 32'h0;
  assign out_pcadd4 = out_valid ? q_pcadd4[rd_ptr] : 32'h0;
  assign out_inst   = out_valid ? q_inst[rd_ptr]   : NOP;

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt    <= 32'h0;
      perf_redirect_cnt <= 32'h0;
    end else if (global_en) begin
      if (!out_valid) perf_stall_cnt    <= perf_stall_cnt + 32'd1;
      if (redirect)   perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven and scoreboard checks of fetch_queue (DEPTH=4,
// MEM_LAT=2) against a gated fixed-latency instruction memory model.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam int          MEM_LAT = 2;
  localparam logic [31:0] RST_PC  = 32'h00400000;
  localparam logic [31:0] NOP     = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        global_en;
  logic        imem_req;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcadd4;
  logic [31:0] out_inst;
  logic [2:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .global_en(global_en),
    .imem_req(imem_req), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pcadd4(out_pcadd4), .out_inst(out_inst),
`ifdef FETCH_QUEUE_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A0F0F;
  endfunction

  // Instruction memory: fixed latency, advanced only on enabled cycles.
  logic [31:0] mem_pipe [MEM_LAT];
  always @(posedge clk) begin
    if (global_en) begin
      mem_pipe[0] <= imem_raddr;
      for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
  end
  assign imem_rdata = inst_of(mem_pipe[MEM_LAT-1]);

  int          nvec = 0;
  int          nfail = 0;
  int          npop = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(i) * 32'd4);
  endtask

  // One cycle: drive at negedge, sample 1ns later, score any pop that will fire.
  task automatic step(input bit en, input bit rdy, input bit rd, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    global_en = en; out_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    if (en && rdy && !rd && out_valid) begin
      npop++;
      if (exp_q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL sb_underflow: unexpected pop of pc %h", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_pcadd4", out_pcadd4, e + 32'd4);
        chk("sb_inst", out_inst, inst_of(e));
      end
    end
    if (en && rd) sb_restart(rpc);
  endtask

  typedef struct {
    bit          en;
    bit          ready;
    bit          valid;
    bit          req;
    int          cnt;
    logic [31:0] pc;
    logic [31:0] raddr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int np0;
    rst_n = 1'b0; global_en = 1'b1; out_ready = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0;

    // Reset fill, then backpressure and a single-cycle release.
    tbl[0]  = '{1, 1, 0, 1, 0, 32'h00000000, 32'h00400000};
    tbl[1]  = '{1, 1, 0, 1, 0, 32'h00000000, 32'h00400004};
    tbl[2]  = '{1, 1, 0, 1, 0, 32'h00000000, 32'h00400008};
    tbl[3]  = '{1, 1, 1, 1, 1, 32'h00400000, 32'h0040000C};
    tbl[4]  = '{1, 1, 1, 1, 1, 32'h00400004, 32'h00400010};
    tbl[5]  = '{1, 1, 1, 1, 1, 32'h00400008, 32'h00400014};
    tbl[6]  = '{1, 0, 1, 1, 1, 32'h0040000C, 32'h00400018};
    tbl[7]  = '{1, 0, 1, 0, 2, 32'h0040000C, 32'h0040001C};
    tbl[8]  = '{1, 0, 1, 0, 3, 32'h0040000C, 32'h0040001C};
    tbl[9]  = '{1, 0, 1, 0, 4, 32'h0040000C, 32'h0040001C};
    tbl[10] = '{1, 0, 1, 0, 4, 32'h0040000C, 32'h0040001C};
    tbl[11] = '{1, 1, 1, 0, 4, 32'h0040000C, 32'h0040001C};
    tbl[12] = '{1, 0, 1, 1, 3, 32'h00400010, 32'h0040001C};
    tbl[13] = '{1, 0, 1, 0, 3, 32'h00400010, 32'h00400020};

    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pcadd4", out_pcadd4, 32'h0);
    chk("rst_inst", out_inst, NOP);
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb_restart(RST_PC);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].ready, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_count", i), 32'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_raddr", i), imem_raddr, tbl[i].raddr);
    end

    // Redirect with a pop request while three entries are queued.
    step(1'b1, 1'b1, 1'b1, 32'h00400100);
    chk("rwp_count_before", 32'(count), 32'd3);
    chk("rwp_req", 32'(imem_req), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rwp_count", 32'(count), 32'd0);
    chk("rwp_valid", 32'(out_valid), 32'd0);
    chk("rwp_req_next", 32'(imem_req), 32'd1);
    chk("rwp_raddr", imem_raddr, 32'h00400100);
`ifdef FETCH_QUEUE_PERF_EN
    chk("rwp_perf_redirect", perf_redirect_cnt, 32'd1);
`endif
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rwp_valid_t2", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rwp_valid_t3", 32'(out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rwp_valid_t4", 32'(out_valid), 32'd1);
    chk("rwp_head", out_pc, 32'h00400100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with two requests in flight; stale responses must vanish.
    step(1'b1, 1'b1, 1'b1, 32'h00400200);
    chk("rif_req", 32'(imem_req), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rif_count", 32'(count), 32'd0);
    chk("rif_raddr", imem_raddr, 32'h00400200);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rif_head", out_pc, 32'h00400200);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Freeze for five cycles mid-stream, then resume.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("frz_pc", out_pc, 32'h0040020C);
      chk("frz_raddr", imem_raddr, 32'h00400218);
      chk("frz_count", 32'(count), 32'd1);
      chk("frz_req", 32'(imem_req), 32'd0);
      chk("frz_valid", 32'(out_valid), 32'd1);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("frz_resume_req", 32'(imem_req), 32'd1);
    chk("frz_resume_raddr", imem_raddr, 32'h00400218);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Fill the queue, then pull reset low between clock edges.
    for (int k = 0; k < 12 && count != 3'd4; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("ar_fill_count", 32'(count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_inst", out_inst, NOP);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    sb_restart(RST_PC);
    np0 = npop;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("ar_refetch_raddr", imem_raddr, RST_PC);
    chk("ar_refetch_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("ar_refetch_pops", 32'(npop - np0), 32'd5);

    // Address wrap across 2^32.
    step(1'b1, 1'b1, 1'b1, 32'hFFFFFFF8);
    np0 = npop;
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_pops", 32'(npop - np0), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
